hdlc_rx_channel: RTL

Serial front end of the HDLC receiver. It samples the line, detects flag and abort patterns, and removes stuffed zeros. It assembles LSB-first data bytes and frames them with ValidFrame, EoF and AbortSignal. Its outputs (Rx_Data, Rx_NewByte, Rx_ValidFrame, Rx_EoF, Rx_AbortSignal, Rx_FrameError) feed the Rx buffer/FCS stage and are the signals the Rx assertion set checks.

---
 rtl/hdlc_rx_channel.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/hdlc_rx_channel.sv
// HDLC receive front end: line sampling, flag/abort detection, zero de-stuffing, byte assembly and framing.
// Optional RX_SYNC_EN inserts a two-flop synchronizer on Rx ahead of RxD.
module hdlc_rx_channel #(
   parameter int MIN_BYTES = 1
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Rx,
   input  logic       Rx_Enable,
   output logic       RxD,
   output logic       Rx_FlagDetect,
   output logic       Rx_AbortDetect,
   output logic       ZeroDetect,
   output logic       Rx_ValidFrame,
   output logic [7:0] Rx_Data,
   output logic       Rx_NewByte,
   output logic       Rx_EoF,
   output logic       Rx_AbortSignal,
   output logic       Rx_FrameError
);

   typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;

   localparam logic [7:0] FLAG_PAT  = 8'h7E;
   localparam logic [7:0] ABORT_PAT = 8'hFE;  // newest bit at MSB: 0 followed by seven 1s
   localparam logic [7:0] MIN_B     = 8'(MIN_BYTES);

   state_t      state, next_state;
   logic        line_in;
   logic [6:0]  pattern;
   logic [7:0]  window;
   logic [2:0]  ones_cnt;
   logic [7:0]  dl_bit, dl_stf, dl_vld;
   logic        take_bit;
   logic [6:0]  shreg;
   logic [2:0]  bit_cnt;
   logic [7:0]  byte_cnt;
   logic        clr_cnt, close_frame, abort_frame;
   logic        eof_pend, err_pend;

`ifdef RX_SYNC_EN
   logic [1:0] sync;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) sync <= 2'b00;
      else      sync <= {sync[0], Rx};
   end

   assign line_in = sync[1];
`else
   assign line_in = Rx;
`endif

   // Line sample and 8-bit window; the newest bit sits at the MSB
   assign window = {RxD, pattern};

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         RxD            <= 1'b0;
         pattern        <= 7'h7F;
         Rx_FlagDetect  <= 1'b0;
         Rx_AbortDetect <= 1'b0;
         ones_cnt       <= 3'd0;
      end else begin
         RxD            <= line_in;
         pattern        <= window[7:1];
         Rx_FlagDetect  <= Rx_Enable && (window == FLAG_PAT);
         Rx_AbortDetect <= Rx_Enable && (window == ABORT_PAT);
         if (RxD) ones_cnt <= (ones_cnt == 3'd7) ? ones_cnt : ones_cnt + 3'd1;
         else     ones_cnt <= 3'd0;
      end
   end

   // Exactly five ones then a zero is a stuffed bit; six ones belong to a flag or abort
   assign ZeroDetect = Rx_ValidFrame && !RxD && (ones_cnt == 3'd5);

   // Delay line: by the time a flag/abort is recognised its own bits are still inside it
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         dl_bit <= 8'h00;
         dl_stf <= 8'h00;
         dl_vld <= 8'h00;
      end else begin
         dl_bit <= {dl_bit[6:0], RxD};
         dl_stf <= {dl_stf[6:0], ZeroDetect};
         if (!Rx_Enable)
            dl_vld <= 8'h00;
         else if (Rx_FlagDetect || Rx_AbortDetect)
            dl_vld <= 8'h01;
         else
            dl_vld <= {dl_vld[6:0], 1'b1};
      end
   end

   assign take_bit = (state == FRAME) && Rx_Enable && dl_vld[7] && !dl_stf[7] &&
                     !Rx_FlagDetect && !Rx_AbortDetect;

   // Framing FSM
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state  = state;
      clr_cnt     = 1'b0;
      close_frame = 1'b0;
      abort_frame = 1'b0;
      if (!Rx_Enable) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (Rx_FlagDetect) begin
                  next_state = FRAME;
                  clr_cnt    = 1'b1;
               end
            end
            FRAME: begin
               if (Rx_FlagDetect) begin
                  if (byte_cnt >= MIN_B) begin
                     next_state  = IDLE;
                     close_frame = 1'b1;
                  end else begin
                     clr_cnt = 1'b1;
                  end
               end else if (Rx_AbortDetect) begin
                  next_state  = IDLE;
                  abort_frame = 1'b1;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   assign Rx_ValidFrame = (state == FRAME);

   // Byte assembly, LSB first
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         shreg      <= 7'd0;
         bit_cnt    <= 3'd0;
         byte_cnt   <= 8'd0;
         Rx_Data    <= 8'd0;
         Rx_NewByte <= 1'b0;
      end else begin
         Rx_NewByte <= take_bit && (bit_cnt == 3'd7);
         if (clr_cnt || close_frame) begin
            bit_cnt  <= 3'd0;
            byte_cnt <= 8'd0;
         end else if (take_bit) begin
            shreg   <= {dl_bit[7], shreg[6:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               Rx_Data  <= {dl_bit[7], shreg};
               byte_cnt <= (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;
            end
         end
      end
   end

   // End-of-frame signalling: EoF trails the ValidFrame fall by one cycle
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         eof_pend       <= 1'b0;
         err_pend       <= 1'b0;
         Rx_EoF         <= 1'b0;
         Rx_FrameError  <= 1'b0;
         Rx_AbortSignal <= 1'b0;
      end else begin
         eof_pend       <= close_frame;
         err_pend       <= close_frame && (bit_cnt != 3'd0);
         Rx_EoF         <= eof_pend && Rx_Enable;
         Rx_FrameError  <= err_pend && Rx_Enable;
         Rx_AbortSignal <= abort_frame;
      end
   end

endmodule
